// File: rtl/lsu_pkg.sv
// Shared types for the per-thread load/store unit: warp/LSU state encodings,
// funct3 size codes and the access-legality helper.
package lsu_pkg;

  localparam int DATA_ADDR_BITS = 8;

  typedef logic [DATA_ADDR_BITS-1:0] data_mem_addr_t;

  typedef enum logic [1:0] {
    LSU_IDLE, LSU_REQUESTING, LSU_DONE, LSU_ERROR
  } lsu_state_t;

  typedef enum logic [2:0] {
    WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST,
    WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE
  } warp_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Unsigned sizes only exist for loads; halves/words must be naturally aligned.
  function automatic logic access_ok(logic is_load, logic [2:0] f3, logic [1:0] lane);
    case (f3)
      F3_B:    access_ok = 1'b1;
      F3_BU:   access_ok = is_load;
      F3_H:    access_ok = !lane[0];
      F3_HU:   access_ok = is_load && !lane[0];
      F3_W:    access_ok = (lane == 2'd0);
      default: access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory read/write handshake between the LSU (master) and memory (slave).
interface lsu_if #(parameter int DATA_ADDR_BITS = 8);

  logic                      mem_read_valid;
  logic [DATA_ADDR_BITS-1:0] mem_read_addr;
  logic                      mem_read_ready;
  logic [31:0]               mem_read_data;
  logic                      mem_write_valid;
  logic [DATA_ADDR_BITS-1:0] mem_write_addr;
  logic [31:0]               mem_write_data;
  logic [3:0]                mem_write_strb;
  logic                      mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_addr, input mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_addr, mem_write_data, mem_write_strb,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_addr, output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_addr, mem_write_data, mem_write_strb,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu_format.sv
// Combinational data formatting: load byte/half extraction with sign/zero
// extension, and store lane replication with byte strobes.
module lsu_format
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] read_data,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] write_data,
  output logic [3:0]  write_strb
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = read_data[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    load_data  = read_data;
    write_data = store_data;
    write_strb = 4'hF;
    case (funct3)
      F3_B: begin
        load_data  = {{24{byte_v[7]}}, byte_v};
        write_data = {4{store_data[7:0]}};
        write_strb = 4'b0001 << lane;
      end
      F3_BU: load_data = {24'd0, byte_v};
      F3_H: begin
        load_data  = {{16{half_v[15]}}, half_v};
        write_data = {2{store_data[15:0]}};
        write_strb = lane[1] ? 4'b1100 : 4'b0011;
      end
      F3_HU:   load_data = {16'd0, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Per-thread load/store unit: one memory transaction per WARP_REQUEST phase,
// using only values latched on entry so the ALU/register inputs may move on.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_ADDR_BITS = lsu_pkg::DATA_ADDR_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  warp_state_t   warp_state,
  input  logic          enable,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    funct3,
  input  logic [31:0]   addr,
  input  logic [31:0]   store_data,
  lsu_if.master         mem,
  output lsu_state_t    lsu_state,
  output logic [31:0]   lsu_out
);

  lsu_state_t                state_q, state_d;
  logic                      is_load_q;
  logic [2:0]                f3_q;
  logic [1:0]                lane_q;
  logic [DATA_ADDR_BITS-1:0] waddr_q;
  logic [31:0]               sdata_q;
  logic [31:0]               out_q;

  logic        req, legal, accept, handshake;
  logic [31:0] fmt_load, fmt_wdata;
  logic [3:0]  fmt_strb;
  logic        unused_addr_hi;

  // Address bits above the data memory size simply wrap.
  assign unused_addr_hi = ^addr[31:DATA_ADDR_BITS+2];

  assign req       = (warp_state == WARP_REQUEST) && enable && (MemRead || MemWrite);
  assign legal     = (MemRead ^ MemWrite) && access_ok(MemRead, funct3, addr[1:0]);
  assign handshake = is_load_q ? mem.mem_read_ready : mem.mem_write_ready;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      LSU_IDLE: if (req) begin
        if (legal) begin
          state_d = LSU_REQUESTING;
          accept  = 1'b1;
        end else begin
          state_d = LSU_ERROR;
        end
      end
      LSU_REQUESTING: if (handshake) state_d = LSU_DONE;
      LSU_DONE, LSU_ERROR: if (warp_state == WARP_UPDATE) state_d = LSU_IDLE;
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LSU_IDLE;
      is_load_q <= 1'b0;
      f3_q      <= 3'd0;
      lane_q    <= 2'd0;
      waddr_q   <= '0;
      sdata_q   <= 32'd0;
      out_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_load_q <= MemRead;
        f3_q      <= funct3;
        lane_q    <= addr[1:0];
        waddr_q   <= addr[DATA_ADDR_BITS+1:2];
        sdata_q   <= store_data;
      end
      if (state_q == LSU_REQUESTING && is_load_q && mem.mem_read_ready)
        out_q <= fmt_load;
      if (state_q == LSU_IDLE && state_d == LSU_ERROR)
        out_q <= 32'd0;
    end
  end

  lsu_format u_format (
    .funct3     (f3_q),
    .lane       (lane_q),
    .read_data  (mem.mem_read_data),
    .store_data (sdata_q),
    .load_data  (fmt_load),
    .write_data (fmt_wdata),
    .write_strb (fmt_strb)
  );

  // Valids derive from state so read and write can never both be high.
  assign mem.mem_read_valid  = (state_q == LSU_REQUESTING) && is_load_q;
  assign mem.mem_write_valid = (state_q == LSU_REQUESTING) && !is_load_q;
  assign mem.mem_read_addr   = waddr_q;
  assign mem.mem_write_addr  = waddr_q;
  assign mem.mem_write_data  = mem.mem_write_valid ? fmt_wdata : 32'd0;
  assign mem.mem_write_strb  = mem.mem_write_valid ? fmt_strb : 4'd0;

  assign lsu_state = state_q;
  assign lsu_out   = out_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, alignment errors, reset abort and
// no-op threads, each step checked against hand-computed values.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  warp_state_t warp_state;
  logic        enable, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  lsu_state_t  lsu_state;
  logic [31:0] lsu_out;

  int n_cmp = 0;
  int n_err = 0;

  lsu_if #(.DATA_ADDR_BITS(8)) mem ();

  lsu #(.DATA_ADDR_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .warp_state (warp_state),
    .enable     (enable),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem        (mem),
    .lsu_state  (lsu_state),
    .lsu_out    (lsu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one memory op for a single REQUEST cycle, then let the warp move on.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    warp_state = WARP_REQUEST; enable = 1'b1;
    MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
    cyc();
    warp_state = WARP_WAIT; MemRead = 1'b0; MemWrite = 1'b0;
    addr = 32'hFFFF_FFFF; funct3 = 3'd7;
  endtask

  task automatic update(input string tag);
    warp_state = WARP_UPDATE;
    cyc();
    check({tag, "_idle"}, 32'(lsu_state), 32'(LSU_IDLE));
    warp_state = WARP_WAIT;
  endtask

  task automatic load_imm(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'd0);
    check({tag, "_req"}, 32'(lsu_state), 32'(LSU_REQUESTING));
    mem.mem_read_ready = 1'b1; mem.mem_read_data = rdata;
    cyc();
    mem.mem_read_ready = 1'b0; mem.mem_read_data = 32'd0;
    check({tag, "_done"}, 32'(lsu_state), 32'(LSU_DONE));
    check({tag, "_out"}, lsu_out, exp);
    update(tag);
  endtask

  initial begin
    reset = 1'b1; warp_state = WARP_IDLE; enable = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    mem.mem_read_ready = 1'b0; mem.mem_read_data = 32'd0; mem.mem_write_ready = 1'b0;
    cyc(); cyc();
    check("rst_state", 32'(lsu_state), 32'(LSU_IDLE));
    check("rst_rvalid", 32'(mem.mem_read_valid), 32'd0);
    check("rst_wvalid", 32'(mem.mem_write_valid), 32'd0);
    check("rst_strb", 32'(mem.mem_write_strb), 32'd0);
    check("rst_out", lsu_out, 32'd0);
    reset = 1'b0;
    cyc();

    // LW 0x10, ready arrives on the third valid cycle
    issue(1'b1, 1'b0, F3_W, 32'h10, 32'd0);
    check("lw_state", 32'(lsu_state), 32'(LSU_REQUESTING));
    check("lw_v1", 32'(mem.mem_read_valid), 32'd1);
    check("lw_addr", 32'(mem.mem_read_addr), 32'd4);
    check("lw_wv", 32'(mem.mem_write_valid), 32'd0);
    cyc();
    check("lw_v2", 32'(mem.mem_read_valid), 32'd1);
    cyc();
    check("lw_v3", 32'(mem.mem_read_valid), 32'd1);
    check("lw_addr3", 32'(mem.mem_read_addr), 32'd4);
    mem.mem_read_ready = 1'b1; mem.mem_read_data = 32'hDEADBEEF;
    cyc();
    mem.mem_read_ready = 1'b0; mem.mem_read_data = 32'd0;
    check("lw_done", 32'(lsu_state), 32'(LSU_DONE));
    check("lw_vdrop", 32'(mem.mem_read_valid), 32'd0);
    check("lw_out", lsu_out, 32'hDEADBEEF);
    cyc();
    check("lw_hold", lsu_out, 32'hDEADBEEF);
    update("lw");

    load_imm("lbu", F3_BU, 32'h13, 32'h80AA5511, 32'h00000080);
    load_imm("lhu", F3_HU, 32'h12, 32'h80AA5511, 32'h000080AA);
    load_imm("lh",  F3_H,  32'h12, 32'h80AA5511, 32'hFFFF80AA);
    load_imm("lb1", F3_B,  32'h11, 32'h80AA5511, 32'h00000055);
    load_imm("lb",  F3_B,  32'h13, 32'h80AA5511, 32'hFFFFFF80);

    // SB with ready immediately available
    mem.mem_write_ready = 1'b1;
    issue(1'b0, 1'b1, F3_B, 32'h21, 32'h12345678);
    check("sb_wv", 32'(mem.mem_write_valid), 32'd1);
    check("sb_rv", 32'(mem.mem_read_valid), 32'd0);
    check("sb_addr", 32'(mem.mem_write_addr), 32'd8);
    check("sb_strb", 32'(mem.mem_write_strb), 32'b0010);
    check("sb_data", mem.mem_write_data, 32'h78787878);
    cyc();
    mem.mem_write_ready = 1'b0;
    check("sb_done", 32'(lsu_state), 32'(LSU_DONE));
    check("sb_wdrop", 32'(mem.mem_write_valid), 32'd0);
    check("sb_out", lsu_out, 32'hFFFFFF80);
    update("sb");

    // SH with store_data changing while the request waits
    issue(1'b0, 1'b1, F3_H, 32'h22, 32'h12345678);
    store_data = 32'h0;
    cyc();
    check("sh_wv", 32'(mem.mem_write_valid), 32'd1);
    check("sh_strb", 32'(mem.mem_write_strb), 32'b1100);
    check("sh_data", mem.mem_write_data, 32'h56785678);
    check("sh_addr", 32'(mem.mem_write_addr), 32'd8);
    mem.mem_write_ready = 1'b1;
    cyc();
    mem.mem_write_ready = 1'b0;
    check("sh_done", 32'(lsu_state), 32'(LSU_DONE));
    update("sh");

    // SW to a wrapped address: 0x404 -> word 0x101 -> 0x01 in 8 bits
    issue(1'b0, 1'b1, F3_W, 32'h404, 32'hCAFEF00D);
    check("sw_addr", 32'(mem.mem_write_addr), 32'd1);
    check("sw_strb", 32'(mem.mem_write_strb), 32'hF);
    check("sw_data", mem.mem_write_data, 32'hCAFEF00D);
    mem.mem_write_ready = 1'b1;
    cyc();
    mem.mem_write_ready = 1'b0;
    update("sw");

    // Error cases never touch memory
    issue(1'b1, 1'b0, F3_W, 32'h11, 32'd0);
    check("mis_state", 32'(lsu_state), 32'(LSU_ERROR));
    check("mis_rv", 32'(mem.mem_read_valid), 32'd0);
    check("mis_out", lsu_out, 32'd0);
    cyc();
    check("mis_rv2", 32'(mem.mem_read_valid), 32'd0);
    update("mis");
    issue(1'b0, 1'b1, F3_BU, 32'h20, 32'd0);
    check("sbu_state", 32'(lsu_state), 32'(LSU_ERROR));
    check("sbu_wv", 32'(mem.mem_write_valid), 32'd0);
    update("sbu");
    issue(1'b1, 1'b1, F3_W, 32'h20, 32'd0);
    check("both_state", 32'(lsu_state), 32'(LSU_ERROR));
    update("both");
    issue(1'b1, 1'b0, F3_H, 32'h13, 32'd0);
    check("lhmis_state", 32'(lsu_state), 32'(LSU_ERROR));
    update("lhmis");

    // Non-participating threads stay idle
    warp_state = WARP_REQUEST; enable = 1'b0; MemRead = 1'b1; funct3 = F3_W; addr = 32'h10;
    cyc();
    check("dis_state", 32'(lsu_state), 32'(LSU_IDLE));
    check("dis_rv", 32'(mem.mem_read_valid), 32'd0);
    enable = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    cyc();
    check("nop_state", 32'(lsu_state), 32'(LSU_IDLE));
    check("nop_wv", 32'(mem.mem_write_valid), 32'd0);
    warp_state = WARP_WAIT;

    // Reset aborts an outstanding request
    load_imm("pre", F3_W, 32'h30, 32'h0BADF00D, 32'h0BADF00D);
    issue(1'b1, 1'b0, F3_W, 32'h40, 32'd0);
    check("abort_req", 32'(lsu_state), 32'(LSU_REQUESTING));
    check("abort_out_before", lsu_out, 32'h0BADF00D);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort_rv", 32'(mem.mem_read_valid), 32'd0);
    check("abort_state", 32'(lsu_state), 32'(LSU_IDLE));
    check("abort_out", lsu_out, 32'd0);
    check("abort_addr", 32'(mem.mem_read_addr), 32'd0);
    cyc();
    check("abort_stay", 32'(lsu_state), 32'(LSU_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
